// File: rtl/riosub_pkg.sv
// riosub_pkg: definitions shared by the riosub transmitter and receiver.
// Provides the frame header, the frame length, the receiver state enum and a header byte lookup.
package riosub_pkg;

    localparam logic [31:0] RIOSUB_HDR = 32'h74697277;
    localparam logic [3:0]  FRAME_LEN  = 4'd9;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        COMMIT  = 2'd2
    } rx_state_e;

    // Header byte by wire position; byte 0 is the MSB of RIOSUB_HDR.
    function automatic logic [7:0] hdr_byte(input logic [1:0] i);
        logic [7:0] b;
        unique case (i)
            2'd0: b = RIOSUB_HDR[31:24];
            2'd1: b = RIOSUB_HDR[23:16];
            2'd2: b = RIOSUB_HDR[15:8];
            default: b = RIOSUB_HDR[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/riosub_rx_uart.sv
// uart_rx: 8N1 UART receiver, LSB first, sampled at mid-bit.
// Ports: clk, RxD (async line in), RxD_data_ready (1-cycle pulse), RxD_data (received byte).
module uart_rx #(
    parameter int ClkFrequency = 12000000,
    parameter int Baud         = 9600
) (
    input  logic       clk,
    input  logic       RxD,
    output logic       RxD_data_ready,
    output logic [7:0] RxD_data
);

    localparam int CPB  = ClkFrequency / Baud;
    localparam int CW   = $clog2(CPB + 1);
    localparam logic [CW-1:0] FULL = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

    // Power-up values: this receiver has no reset input.
    uart_state_e   st_q   = S_IDLE;
    logic [1:0]    sync_q = 2'b11;
    logic [CW-1:0] cnt_q  = '0;
    logic [2:0]    bit_q  = '0;
    logic [7:0]    sh_q   = '0;
    logic [7:0]    data_q = '0;
    logic          rdy_q  = 1'b0;

    wire line = sync_q[1];

    always_ff @(posedge clk) begin
        sync_q <= {sync_q[0], RxD};
        rdy_q  <= 1'b0;
        unique case (st_q)
            S_IDLE: begin
                if (!line) begin
                    st_q  <= S_START;
                    cnt_q <= HALF;
                end
            end
            S_START: begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else if (!line) begin
                    st_q  <= S_DATA;
                    cnt_q <= FULL;
                    bit_q <= '0;
                end else begin
                    // Glitch, not a real start bit.
                    st_q <= S_IDLE;
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    sh_q  <= {line, sh_q[7:1]};
                    cnt_q <= FULL;
                    bit_q <= bit_q + 1'b1;
                    if (bit_q == 3'd7) st_q <= S_STOP;
                end
            end
            default: begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    // Framing error drops the byte.
                    if (line) begin
                        data_q <= sh_q;
                        rdy_q  <= 1'b1;
                    end
                    st_q <= S_IDLE;
                end
            end
        endcase
    end

    assign RxD_data_ready = rdy_q;
    assign RxD_data       = data_q;

endmodule

// File: rtl/riosub_rx.sv
// riosub_rx: sub-board receiver; deframes 9-byte riosub frames into a held PWM duty/enable.
// Ports: clk, rst (async high), rx (UART), pwmout2_dty/enable, frame_valid/error pulses, link_ok.
module riosub_rx
    import riosub_pkg::*;
#(
    parameter int ClkFrequency = 12000000,
    parameter int Baud         = 9600,
    parameter int BYTE_TIMEOUT = 120000,
    parameter int WATCHDOG     = 4000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic signed [31:0] pwmout2_dty,
    output logic               pwmout2_enable,
    output logic               frame_valid,
    output logic               frame_error,
    output logic               link_ok
);

    localparam int GW = $clog2(BYTE_TIMEOUT + 1);
    localparam int WW = $clog2(WATCHDOG + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(BYTE_TIMEOUT - 1);
    localparam logic [WW-1:0] WD_MAX   = WW'(WATCHDOG);
    localparam logic [3:0]    LAST_IDX = FRAME_LEN - 4'd1;

    logic       rx_rdy;
    logic [7:0] rx_byte;

    uart_rx #(
        .ClkFrequency(ClkFrequency),
        .Baud        (Baud)
    ) u_uart (
        .clk           (clk),
        .RxD           (rx),
        .RxD_data_ready(rx_rdy),
        .RxD_data      (rx_byte)
    );

    rx_state_e     state_q;
    logic [3:0]    idx_q;
    logic [31:0]   shadow_q;
    logic [31:0]   dty_q;
    logic          en_q;
    logic          fv_q;
    logic          fe_q;
    logic [GW-1:0] gap_q;
    logic [WW-1:0] wd_q;

    logic gap_run;
    logic timeout;

    assign gap_run = (idx_q != 4'd0) || (state_q == PAYLOAD);
    // A byte arriving in the timeout cycle takes priority.
    assign timeout = gap_run && !rx_rdy && (gap_q == GAP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HUNT;
            idx_q    <= 4'd0;
            shadow_q <= '0;
            dty_q    <= '0;
            en_q     <= 1'b0;
            fv_q     <= 1'b0;
            fe_q     <= 1'b0;
            gap_q    <= '0;
            wd_q     <= WD_MAX;
        end else begin
            fv_q <= 1'b0;
            fe_q <= 1'b0;

            if (wd_q != WD_MAX) wd_q <= wd_q + 1'b1;

            if (rx_rdy || !gap_run || timeout) gap_q <= '0;
            else gap_q <= gap_q + 1'b1;

            if (state_q == COMMIT) begin
                // Outputs were already loaded with the last byte.
                state_q <= HUNT;
                idx_q   <= 4'd0;
            end else if (rx_rdy) begin
                if (state_q == HUNT) begin
                    if (rx_byte == hdr_byte(idx_q[1:0])) begin
                        if (idx_q == 4'd3) state_q <= PAYLOAD;
                        idx_q <= idx_q + 4'd1;
                    end else if (rx_byte == hdr_byte(2'd0)) begin
                        idx_q <= 4'd1;
                    end else begin
                        idx_q <= 4'd0;
                    end
                end else if (idx_q == LAST_IDX) begin
                    if (rx_byte[6:0] == 7'd0) begin
                        // Commit on this edge so outputs land one cycle after ready.
                        dty_q   <= shadow_q;
                        en_q    <= rx_byte[7];
                        fv_q    <= 1'b1;
                        wd_q    <= '0;
                        state_q <= COMMIT;
                    end else begin
                        fe_q    <= 1'b1;
                        state_q <= HUNT;
                        idx_q   <= 4'd0;
                    end
                end else begin
                    shadow_q <= {shadow_q[23:0], rx_byte};
                    idx_q    <= idx_q + 4'd1;
                end
            end else if (timeout) begin
                if (state_q == PAYLOAD) fe_q <= 1'b1;
                state_q <= HUNT;
                idx_q   <= 4'd0;
            end
        end
    end

    assign link_ok        = (wd_q != WD_MAX);
    assign pwmout2_dty    = dty_q;
    assign pwmout2_enable = en_q & link_ok;
    assign frame_valid    = fv_q;
    assign frame_error    = fe_q;

endmodule

// File: tb/tb_riosub_rx.sv
// tb_riosub_rx: drives riosub frames over the UART line and scoreboards frame pulses/outputs.
// Ports: none (top-level bench).
module tb_riosub_rx;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 62500;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int BTO    = 400;
    localparam int WD     = 5000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               rx  = 1'b1;
    logic signed [31:0] pwmout2_dty;
    logic               pwmout2_enable;
    logic               frame_valid;
    logic               frame_error;
    logic               link_ok;

    riosub_rx #(
        .ClkFrequency(CLK_HZ),
        .Baud        (BAUD),
        .BYTE_TIMEOUT(BTO),
        .WATCHDOG    (WD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .pwmout2_dty   (pwmout2_dty),
        .pwmout2_enable(pwmout2_enable),
        .frame_valid   (frame_valid),
        .frame_error   (frame_error),
        .link_ok       (link_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [31:0] dty;
        bit          en;
        bit          link;
    } ev_t;

    typedef struct {
        logic [95:0] b;
        int          n;
        bit          err;
        logic [31:0] dty;
        bit          en;
    } vec_t;

    ev_t  sb[$];
    vec_t vecs[7];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_bytes(input logic [95:0] b, input int n);
        for (int i = 0; i < n; i++) send_byte(b[95-8*i -: 8]);
    endtask

    task automatic expect_ev(input bit err, input logic [31:0] dty, input bit en, input bit link);
        ev_t e;
        e.err  = err;
        e.dty  = dty;
        e.en   = en;
        e.link = link;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string nm);
        repeat (4) @(negedge clk);
        chk(nm, sb.size(), 0);
        sb.delete();
    endtask

    // Scoreboard consumer: every pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (frame_valid || frame_error) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: valid=%b error=%b with no event expected",
                         frame_valid, frame_error);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("pulse_kind_err", {31'd0, frame_error}, {31'd0, e.err});
                chk("pulse_kind_val", {31'd0, frame_valid}, {31'd0, !e.err});
                chk("pulse_dty", pwmout2_dty, e.dty);
                chk("pulse_en", {31'd0, pwmout2_enable}, {31'd0, e.en});
                chk("pulse_link", {31'd0, link_ok}, {31'd0, e.link});
            end
        end
    end

    initial begin
        vecs[0] = '{96'h74697277_000003E8_80000000,  9, 1'b0, 32'd1000,       1'b1};
        vecs[1] = '{96'h55747469_7277FFFF_FFFE0000, 11, 1'b0, 32'hFFFFFFFE,   1'b0};
        vecs[2] = '{96'h74697277_12345678_80000000,  9, 1'b0, 32'h12345678,   1'b1};
        vecs[3] = '{96'h74697277_AABBCCDD_81000000,  9, 1'b1, 32'h12345678,   1'b1};
        vecs[4] = '{96'h74747469_72770000_00058000, 11, 1'b0, 32'd5,          1'b1};
        vecs[5] = '{96'h74690074_69727700_00000700, 12, 1'b0, 32'd7,          1'b0};
        vecs[6] = '{96'h74697277_00000063_40000000,  9, 1'b1, 32'd7,          1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dty", pwmout2_dty, 32'd0);
        chk("rst_en", {31'd0, pwmout2_enable}, 32'd0);
        chk("rst_link", {31'd0, link_ok}, 32'd0);
        chk("rst_fv", {31'd0, frame_valid}, 32'd0);
        chk("rst_fe", {31'd0, frame_error}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_link", {31'd0, link_ok}, 32'd0);

        // Table-driven frames
        for (int v = 0; v < 7; v++) begin
            expect_ev(vecs[v].err, vecs[v].dty, vecs[v].en, 1'b1);
            send_bytes(vecs[v].b, vecs[v].n);
            wait_drain("vec_pending");
            chk("vec_dty", pwmout2_dty, vecs[v].dty);
            chk("vec_en", {31'd0, pwmout2_enable}, {31'd0, vecs[v].en});
            chk("vec_link", {31'd0, link_ok}, 32'd1);
        end

        // Byte timeout inside the payload, then recovery
        expect_ev(1'b1, 32'd7, 1'b0, 1'b1);
        send_bytes(96'h74697277_01000000_00000000, 5);
        repeat (BTO + 50) @(negedge clk);
        wait_drain("timeout_pending");
        chk("timeout_dty", pwmout2_dty, 32'd7);
        expect_ev(1'b0, 32'd9, 1'b1, 1'b1);
        send_bytes(96'h74697277_00000009_80000000, 9);
        wait_drain("recover_pending");

        // Watchdog expiry and restore
        repeat (WD - 200) @(negedge clk);
        chk("wd_before_link", {31'd0, link_ok}, 32'd1);
        chk("wd_before_en", {31'd0, pwmout2_enable}, 32'd1);
        repeat (400) @(negedge clk);
        chk("wd_link", {31'd0, link_ok}, 32'd0);
        chk("wd_en", {31'd0, pwmout2_enable}, 32'd0);
        chk("wd_dty", pwmout2_dty, 32'd9);
        expect_ev(1'b0, 32'd10, 1'b1, 1'b1);
        send_bytes(96'h74697277_0000000A_80000000, 9);
        wait_drain("wd_restore_pending");
        chk("wd_restore_en", {31'd0, pwmout2_enable}, 32'd1);

        // Partial header timeout is silent and forgets the match
        send_bytes(96'h74690000_00000000_00000000, 2);
        repeat (BTO + 50) @(negedge clk);
        send_bytes(96'h72770000_000B8000_00000000, 7);
        wait_drain("hdr_to_pending");
        chk("hdr_to_dty", pwmout2_dty, 32'd10);

        // Reset during byte 6 aborts the frame
        send_bytes(96'h74697277_00000000_00000000, 5);
        fork
            send_byte(8'h00);
            begin
                repeat (4 * CPB) @(negedge clk);
                rst = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
            end
        join
        send_bytes(96'h000D8000_00000000_00000000, 3);
        wait_drain("abort_pending");
        chk("abort_dty", pwmout2_dty, 32'd0);
        chk("abort_link", {31'd0, link_ok}, 32'd0);
        expect_ev(1'b0, 32'd14, 1'b1, 1'b1);
        send_bytes(96'h74697277_0000000E_80000000, 9);
        wait_drain("after_abort_pending");
        chk("after_abort_dty", pwmout2_dty, 32'd14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
